mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between the pipeline's instruction-fetch port (IF) and data-memory port (DM, MEM stage).
- Sits between the MIPS core and the memory. It serialises accesses, returns read data, and produces per-port stall signals for the pipeline hazard logic.
- Data port has priority. A run-length limit prevents instruction-fetch starvation.
- A packed debug word is exported for the board display mux.

---
 rtl/mem_port_arbiter.sv | 85 ++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency single-port memory between the IF and DM ports,
// DM first, with a run limit so a waiting fetch is never starved.
module mem_port_arbiter #(
  parameter int LAT        = 2,
  parameter int MAX_DM_RUN = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m,
  output logic [31:0] dbg
);
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, RESP = 2'b10} state_t;
  state_t     state;
  logic       owner;
  logic [3:0] dmRun;
  logic [3:0] latCnt;
  logic       grantIf;
  assign grantIf = if_req & (~dm_req | (dmRun == 4'(MAX_DM_RUN)));
  assign stall_f = if_req & ~if_ready;
  assign stall_m = dm_req & ~dm_ready;
  assign dbg     = {24'b0, state, owner, 1'b0, dmRun};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= 1'b0;
      dmRun     <= 4'd0;
      latCnt    <= 4'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      if_rdata  <= 32'd0;
      dm_rdata  <= 32'd0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      mem_en   <= 1'b0;
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          // a DM win while IF waits can only happen below the limit, so +1 never overflows it
          dmRun <= (!if_req || grantIf) ? 4'd0 : dmRun + 4'd1;
          if (if_req || dm_req) begin
            state    <= BUSY;
            owner    <= ~grantIf;
            mem_en   <= 1'b1;
            latCnt   <= 4'(LAT - 1);
            mem_addr <= grantIf ? if_addr : dm_addr;
            mem_we   <= ~grantIf & dm_we;
            if (!grantIf) mem_wdata <= dm_wdata;
          end
        end
        BUSY: begin
          latCnt <= latCnt - 4'd1;
          if (latCnt == 4'd0) begin
            state    <= RESP;
            if_ready <= ~owner;
            dm_ready <= owner;
            if (!mem_we && !owner) if_rdata <= mem_rdata;
            if (!mem_we && owner) dm_rdata <= mem_rdata;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus random traffic, checked every cycle against
// a transaction-level model of the arbiter and a latency-accurate memory model.
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  localparam int MAX_DM_RUN = 4;

  logic clk = 1'b0, reset;
  logic if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata = 32'd0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, dbg;
  logic if_ready, dm_ready, mem_en, mem_we, stall_f, stall_m;

  int tests = 0, fails = 0;

  mem_port_arbiter #(.LAT(LAT), .MAX_DM_RUN(MAX_DM_RUN)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .stall_f(stall_f), .stall_m(stall_m), .dbg(dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory: contents in a sparse array, unwritten words derived from the address.
  logic [31:0] memArr [logic [31:0]];
  function automatic logic [31:0] memRead(input logic [31:0] a);
    return memArr.exists(a) ? memArr[a] : {a[15:0], ~a[15:0]};
  endfunction

  int age = 99;
  logic [31:0] mAddr = 32'd0;
  always @(posedge clk) begin
    #1;
    if (mem_en) begin
      age = 0;
      mAddr = mem_addr;
      if (mem_we) memArr[mem_addr] = mem_wdata;
    end else if (age < 99) age++;
    mem_rdata = (age == LAT - 1) ? memRead(mAddr) : $urandom;
  end

  // Reference model: an access occupies LAT busy cycles plus one response cycle.
  int left = 0;
  logic ownerM = 1'b0, eEn = 1'b0, eWe = 1'b0, eIfRdy = 1'b0, eDmRdy = 1'b0;
  logic [3:0] runM = 4'd0;
  logic [31:0] eAddr = 32'd0, eWdata = 32'd0, eIfR = 32'd0, eDmR = 32'd0;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      left = 0; ownerM = 0; runM = 0; eEn = 0; eWe = 0; eIfRdy = 0; eDmRdy = 0;
      eAddr = 0; eWdata = 0; eIfR = 0; eDmR = 0;
    end else begin
      eEn = 0; eIfRdy = 0; eDmRdy = 0;
      if (left == 0) begin
        if (if_req && (!dm_req || runM == MAX_DM_RUN)) begin
          left = LAT + 1; ownerM = 0; eAddr = if_addr; eWe = 0; eEn = 1; runM = 0;
        end else if (dm_req) begin
          left = LAT + 1; ownerM = 1; eAddr = dm_addr; eWe = dm_we; eWdata = dm_wdata; eEn = 1;
          runM = !if_req ? 4'd0 : (runM == MAX_DM_RUN ? runM : runM + 4'd1);
        end else runM = 0;
      end else begin
        left--;
        if (left == 1) begin
          if (ownerM) eDmRdy = 1; else eIfRdy = 1;
          if (!eWe && ownerM) eDmR = memRead(eAddr);
          if (!eWe && !ownerM) eIfR = memRead(eAddr);
        end
      end
    end
  end

  logic [1:0] stM;
  assign stM = left == 0 ? 2'b00 : left == 1 ? 2'b10 : 2'b01;

  always @(negedge clk) begin
    chk("mem_en", 32'(mem_en), 32'(eEn));
    chk("mem_we", 32'(mem_we), 32'(eWe));
    chk("mem_addr", mem_addr, eAddr);
    chk("mem_wdata", mem_wdata, eWdata);
    chk("if_ready", 32'(if_ready), 32'(eIfRdy));
    chk("dm_ready", 32'(dm_ready), 32'(eDmRdy));
    chk("if_rdata", if_rdata, eIfR);
    chk("dm_rdata", dm_rdata, eDmR);
    chk("stall_f", 32'(stall_f), 32'(if_req & ~eIfRdy));
    chk("stall_m", 32'(stall_m), 32'(dm_req & ~eDmRdy));
    chk("dbg", dbg, {24'b0, stM, ownerM, 1'b0, runM});
  end

  task automatic waitRdy(input bit dm, output int n);
    n = 0;
    while (!(dm ? dm_ready : if_ready) && n < 40) begin
      tick();
      n++;
    end
    chk(dm ? "dm_ready_wait" : "if_ready_wait", 32'(dm ? dm_ready : if_ready), 32'd1);
  endtask

  function automatic logic [31:0] rndAddr();
    return {26'b0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n, cyc, grants;
  int expOwn[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
  int expRun[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

  initial begin
    reset = 1; if_req = 0; dm_req = 0; dm_we = 0; if_addr = 0; dm_addr = 0; dm_wdata = 0;
    memArr[32'h40] = 32'h2008000A;
    #1 reset = 0;
    for (int i = 0; i < 5; i++) begin
      if_req = 1'($urandom); dm_req = 1'($urandom); dm_we = 1'($urandom);
      if_addr = $urandom; dm_addr = $urandom; dm_wdata = $urandom;
      tick();
      chk("rst_mem_en", 32'(mem_en), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", if_rdata | dm_rdata, 32'd0);
      chk("rst_ready", 32'({if_ready, dm_ready}), 32'd0);
      chk("rst_dbg", dbg, 32'd0);
    end
    if_req = 1; if_addr = 0; dm_req = 0; dm_we = 0; reset = 1;
    tick();
    chk("post_rst_grant", 32'(mem_en), 32'd1);
    waitRdy(0, n);
    if_req = 0;
    tick();
    // IF read
    if_req = 1; if_addr = 32'h40;
    tick();
    chk("ifrd_en", 32'(mem_en), 32'd1);
    chk("ifrd_addr", mem_addr, 32'h40);
    tick();
    chk("ifrd_en_off", 32'(mem_en), 32'd0);
    chk("ifrd_early", 32'(if_ready), 32'd0);
    tick();
    chk("ifrd_ready", 32'(if_ready), 32'd1);
    chk("ifrd_data", if_rdata, 32'h2008000A);
    if_req = 0;
    tick();
    chk("ifrd_pulse", 32'(if_ready), 32'd0);
    chk("ifrd_stall", 32'(stall_f), 32'd0);
    // DM write
    dm_req = 1; dm_we = 1; dm_addr = 32'h54; dm_wdata = 32'hDEADBEEF;
    tick();
    chk("dmwr_en", 32'({mem_en, mem_we}), 32'd3);
    chk("dmwr_addr", mem_addr, 32'h54);
    chk("dmwr_wdata", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("dmwr_hold", 32'({mem_en, mem_we}), 32'd1);
    chk("dmwr_addr2", mem_addr, 32'h54);
    chk("dmwr_wdata2", mem_wdata, 32'hDEADBEEF);
    tick();
    chk("dmwr_ready", 32'(dm_ready), 32'd1);
    chk("dmwr_rdata", dm_rdata, 32'd0);
    dm_req = 0;
    tick();
    // Contention: both ports held high
    if_req = 1; if_addr = 32'h44; dm_req = 1; dm_we = 1; dm_addr = 32'h70; dm_wdata = 32'h12345678;
    grants = 0; cyc = 0;
    while (grants < 10 && cyc < 200) begin
      tick();
      cyc++;
      if (mem_en) begin
        chk("cont_owner", 32'(dbg[5]), 32'(expOwn[grants]));
        chk("cont_run", 32'(dbg[3:0]), 32'(expRun[grants]));
        grants++;
      end
    end
    chk("cont_grants", 32'(grants), 32'd10);
    if_req = 0; dm_req = 0;
    repeat (5) tick();
    // Reset in the second busy cycle of a DM read
    dm_req = 1; dm_we = 0; dm_addr = 32'h60;
    tick();
    chk("midrst_grant", 32'(mem_en), 32'd1);
    tick();
    reset = 0;
    tick();
    chk("midrst_noready", 32'(dm_ready), 32'd0);
    chk("midrst_rdata", dm_rdata, 32'd0);
    chk("midrst_dbg", dbg, 32'd0);
    reset = 1;
    tick();
    chk("midrst_regrant", 32'(mem_en), 32'd1);
    chk("midrst_addr", mem_addr, 32'h60);
    waitRdy(1, n);
    chk("midrst_data", dm_rdata, 32'h0060FF9F);
    dm_req = 0;
    tick();
    // Back-to-back DM reads
    dm_req = 1; dm_we = 0; dm_addr = 32'h54; n = 0;
    tick(); n++;
    chk("b2b_grant1", 32'(mem_en), 32'd1);
    waitRdy(1, cyc); n += cyc;
    chk("b2b_data1", dm_rdata, 32'hDEADBEEF);
    dm_addr = 32'h58;
    tick(); n++;
    chk("b2b_resp_nogrant", 32'(mem_en), 32'd0);
    chk("b2b_idle", 32'(dbg[7:6]), 32'd0);
    tick(); n++;
    chk("b2b_grant2", 32'(mem_en), 32'd1);
    chk("b2b_addr2", mem_addr, 32'h58);
    waitRdy(1, cyc); n += cyc;
    chk("b2b_cycles", 32'(n + 1), 32'd8);
    dm_req = 0;
    tick();
    // Random traffic with occasional asynchronous resets
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 199) == 0) begin
        reset = 0;
        tick();
        reset = 1;
      end
      if (if_ready || !if_req) begin
        if_req = $urandom_range(0, 9) < 6; if_addr = rndAddr();
      end else if ($urandom_range(0, 63) == 0) if_req = 0;
      if (dm_ready || !dm_req) begin
        dm_req = $urandom_range(0, 9) < 6; dm_addr = rndAddr();
        dm_we = 1'($urandom); dm_wdata = $urandom;
      end else if ($urandom_range(0, 63) == 0) dm_req = 0;
    end
    if_req = 0; dm_req = 0;
    repeat (6) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
